// File: rtl/seq1010_pkg.sv
// Shared definitions for the 1010 sync link: detector state encoding, sync word
// and the transmitter's frame phases.
package seq1010_pkg;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } det_state_e;

    localparam logic [3:0] SYNC_WORD = 4'b1010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        TAIL = 3'd3,
        GAP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/seq1010_next_state.sv
// Next-state function of the non-overlapping 1010 Mealy detector.
// A hit (S101 with a '0') returns to S0, so matches never overlap.
module seq1010_next_state
    import seq1010_pkg::*;
(
    input  det_state_e state_i,
    input  logic       bit_i,
    output det_state_e state_o
);

    always_comb begin
        state_o = S0;
        unique case (state_i)
            S0:   state_o = bit_i ? S1   : S0;
            S1:   state_o = bit_i ? S1   : S10;
            S10:  state_o = bit_i ? S101 : S0;
            S101: state_o = bit_i ? S1   : S0;
            default: state_o = S0;
        endcase
    end

endmodule

// File: rtl/mealy_1010_frame_tx.sv
// Serial frame transmitter: 1010 sync, bit-stuffed MSB-first payload, optional
// tail stuff bit and a forced-zero gap, one bit per clock on a registered OP.
module mealy_1010_frame_tx
    import seq1010_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_MIN = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic              OP,
    output logic              Tx_Busy,
    output logic              Stuff
);

    localparam int BIT_CNT_W = $clog2(DATA_W + 1);
    localparam int PH_MAX    = (GAP_MIN > 4) ? GAP_MIN : 4;
    localparam int PH_CNT_W  = $clog2(PH_MAX + 1);

    // State describes the bit currently on OP; ph_cnt counts sync/gap bits already driven.
    tx_state_e             state_q, state_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PH_CNT_W-1:0]   ph_cnt_q, ph_cnt_d;
    det_state_e            shadow_q, shadow_d;
    logic                  op_q, op_d;
    logic                  stuff_q, stuff_d;

    det_state_e shadow_adv;
    logic       last_done;
    logic       sync_last;
    logic [1:0] sync_idx;
    tx_state_e  step_state;
    logic       step_op;
    logic       step_stuff;
    logic       step_consume;

    seq1010_next_state u_shadow_ns (
        .state_i (shadow_q),
        .bit_i   (data_q[DATA_W-1]),
        .state_o (shadow_adv)
    );

    assign last_done = (bit_cnt_q == BIT_CNT_W'(DATA_W));
    assign sync_last = (state_q == SYNC) && (ph_cnt_q == PH_CNT_W'(4));
    assign sync_idx  = 2'(3 - int'(ph_cnt_q));

    // Choice of the next bit once the sync word is out: stuff, payload, or leave DATA.
    always_comb begin
        step_state   = DATA;
        step_op      = 1'b0;
        step_stuff   = 1'b0;
        step_consume = 1'b0;
        if (shadow_q == S101) begin
            step_op    = 1'b1;
            step_stuff = 1'b1;
            step_state = last_done ? TAIL : DATA;
        end else if (last_done) begin
            step_state = GAP;
        end else begin
            step_op      = data_q[DATA_W-1];
            step_consume = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        ph_cnt_d  = ph_cnt_q;
        shadow_d  = shadow_q;
        op_d      = 1'b0;
        stuff_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (In_Valid) begin
                    state_d   = SYNC;
                    data_d    = In_Data;
                    bit_cnt_d = '0;
                    ph_cnt_d  = PH_CNT_W'(1);
                    shadow_d  = S0;
                    op_d      = SYNC_WORD[3];
                end
            end
            SYNC: begin
                if (!sync_last) begin
                    ph_cnt_d = ph_cnt_q + PH_CNT_W'(1);
                    op_d     = SYNC_WORD[sync_idx];
                end
            end
            TAIL: begin
                state_d  = GAP;
                ph_cnt_d = PH_CNT_W'(1);
            end
            GAP: begin
                if (ph_cnt_q == PH_CNT_W'(GAP_MIN)) begin
                    state_d  = IDLE;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (state_q == DATA || sync_last) begin
            state_d = step_state;
            op_d    = step_op;
            stuff_d = step_stuff;
            if (step_stuff) begin
                shadow_d = S1;
            end
            if (step_consume) begin
                shadow_d  = shadow_adv;
                data_d    = data_q << 1;
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
            if (step_state == GAP) begin
                ph_cnt_d = PH_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            ph_cnt_q  <= '0;
            shadow_q  <= S0;
            op_q      <= 1'b0;
            stuff_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            ph_cnt_q  <= ph_cnt_d;
            shadow_q  <= shadow_d;
            op_q      <= op_d;
            stuff_q   <= stuff_d;
        end
    end

    assign OP       = op_q;
    assign Stuff    = stuff_q;
    assign Tx_Busy  = (state_q != IDLE);
    assign In_Ready = (state_q == IDLE);

endmodule

// File: tb/tb_mealy_1010_frame_tx.sv
// Bench for mealy_1010_frame_tx: OP is looped into a behavioural 1010 detector and
// compared cycle by cycle against frames built from the stuffing rule on bit lists.
module tb_mealy_1010_frame_tx;

    localparam int DATA_W  = 8;
    localparam int GAP_MIN = 2;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic [DATA_W-1:0] In_Data = '0;
    logic              In_Valid = 1'b0;
    logic              In_Ready;
    logic              OP;
    logic              Tx_Busy;
    logic              Stuff;

    mealy_1010_frame_tx #(.DATA_W(DATA_W), .GAP_MIN(GAP_MIN)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .OP       (OP),
        .Tx_Busy  (Tx_Busy),
        .Stuff    (Stuff)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic              op;
        logic              stuff;
        logic              last_sync;
        logic              region;
        logic              first_gap;
        logic [DATA_W-1:0] word;
    } exp_t;

    exp_t              expq[$];
    logic [DATA_W-1:0] pending[$];
    logic              det_hist[$];
    logic              region_bits[$];
    logic              idle_now = 1'b1;
    logic              holdoff_en = 1'b0;
    int                frames = 0;
    int                hits = 0;
    int                n_checks = 0;
    int                n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic ends101(input logic q[$]);
        int n;
        n = q.size();
        if (n < 3) return 1'b0;
        return (q[n-3] == 1'b1) && (q[n-2] == 1'b0) && (q[n-1] == 1'b1);
    endfunction

    // Expected frame: sync word, then payload with a '1' inserted whenever the
    // bits sent so far after sync end in 101, then the zero gap.
    function automatic void build(input logic [DATA_W-1:0] w);
        logic sw[4];
        logic d[$];
        logic s[$];
        exp_t e;
        sw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            e = '{op: sw[i], stuff: 1'b0, last_sync: (i == 3), region: 1'b0, first_gap: 1'b0, word: w};
            expq.push_back(e);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (ends101(d)) begin d.push_back(1'b1); s.push_back(1'b1); end
            d.push_back(w[i]);
            s.push_back(1'b0);
        end
        if (ends101(d)) begin d.push_back(1'b1); s.push_back(1'b1); end
        for (int i = 0; i < d.size(); i++) begin
            e = '{op: d[i], stuff: s[i], last_sync: 1'b0, region: 1'b1, first_gap: 1'b0, word: w};
            expq.push_back(e);
        end
        for (int i = 0; i < GAP_MIN; i++) begin
            e = '{op: 1'b0, stuff: 1'b0, last_sync: 1'b0, region: 1'b0, first_gap: (i == 0), word: w};
            expq.push_back(e);
        end
    endfunction

    // Receiver-side de-stuffing: a bit following 101 is dropped.
    function automatic logic [DATA_W-1:0] destuff(input logic q[$], output int nbits);
        logic seen[$];
        logic [DATA_W-1:0] w;
        w = '0;
        nbits = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (ends101(seen)) begin
                seen.push_back(q[i]);
            end else begin
                seen.push_back(q[i]);
                if (nbits < DATA_W) w = {w[DATA_W-2:0], q[i]};
                nbits++;
            end
        end
        return w;
    endfunction

    always @(posedge Clk) begin
        if (Rst && idle_now && In_Valid) begin
            build(In_Data);
            if (pending.size() > 0) void'(pending.pop_front());
            frames++;
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        logic hit;
        logic [DATA_W-1:0] rec;
        int nb;
        if (!Rst) begin
            check("rst_op", 32'(OP), 32'd0);
            check("rst_busy", 32'(Tx_Busy), 32'd0);
            check("rst_stuff", 32'(Stuff), 32'd0);
            check("rst_ready", 32'(In_Ready), 32'd1);
            idle_now = 1'b1;
            det_hist.delete();
        end else begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
                idle_now = 1'b0;
            end else begin
                e = '{op: 1'b0, stuff: 1'b0, last_sync: 1'b0, region: 1'b0, first_gap: 1'b0, word: '0};
                idle_now = 1'b1;
            end
            check("op", 32'(OP), 32'(e.op));
            check("stuff", 32'(Stuff), 32'(e.stuff));
            check("busy", 32'(Tx_Busy), 32'(!idle_now));
            check("ready", 32'(In_Ready), 32'(idle_now));
            det_hist.push_back(OP);
            hit = 1'b0;
            if (det_hist.size() >= 4) begin
                int n;
                n = det_hist.size();
                hit = (det_hist[n-4] == 1'b1) && (det_hist[n-3] == 1'b0) &&
                      (det_hist[n-2] == 1'b1) && (det_hist[n-1] == 1'b0);
            end
            if (hit) begin
                det_hist.delete();
                hits++;
            end else if (det_hist.size() > 3) begin
                void'(det_hist.pop_front());
            end
            check("det_hit", 32'(hit), 32'(e.last_sync));
            if (e.region) region_bits.push_back(OP);
            if (e.first_gap) begin
                rec = destuff(region_bits, nb);
                check("destuff_word", 32'(rec), 32'(e.word));
                check("destuff_len", 32'(nb), 32'(DATA_W));
                region_bits.delete();
            end
        end
    end

    always @(negedge Clk) begin
        #1;
        if (Rst && pending.size() > 0 && !(idle_now && holdoff_en && $urandom_range(3) == 0)) begin
            In_Valid = 1'b1;
            In_Data  = idle_now ? pending[0] : DATA_W'($urandom);
        end else begin
            In_Valid = 1'b0;
            In_Data  = DATA_W'($urandom);
        end
    end

    task automatic wait_accept(input int f0);
        for (int i = 0; i < 200 && frames == f0; i++) begin
            @(posedge Clk);
            #1;
        end
        check("accept_seen", 32'(frames != f0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && !(pending.size() == 0 && expq.size() == 0 && idle_now)) begin
            @(posedge Clk);
            i++;
        end
        check("idle_reached", 32'(i < budget), 32'd1);
        @(negedge Clk);
    endtask

    task automatic capture(input logic [DATA_W-1:0] w, input int n,
                           output logic [31:0] op_v, output logic [31:0] st_v,
                           output int busy_n, output int nready_n);
        int f0;
        f0 = frames;
        pending.push_back(w);
        wait_accept(f0);
        op_v = '0;
        st_v = '0;
        busy_n = 0;
        nready_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            #2;
            op_v = {op_v[30:0], OP};
            st_v = {st_v[30:0], Stuff};
            busy_n += int'(Tx_Busy);
            nready_n += int'(!In_Ready);
        end
    endtask

    initial begin
        logic [31:0] op_v;
        logic [31:0] st_v;
        int busy_n;
        int nready_n;
        int f0;

        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        #3 Rst = 1'b1;
        repeat (2) @(negedge Clk);

        capture(8'hFF, 15, op_v, st_v, busy_n, nready_n);
        check("ff_op", op_v, 32'b101011111111000);
        check("ff_stuff", st_v, 32'd0);
        check("ff_busy_cycles", 32'(busy_n), 32'd14);
        check("ff_notready_cycles", 32'(nready_n), 32'd14);
        wait_idle(100);

        capture(8'hAA, 17, op_v, st_v, busy_n, nready_n);
        check("aa_op", op_v, 32'b10101011011011000);
        check("aa_stuff", st_v, 32'b00000001001001000);
        wait_idle(100);

        capture(8'h05, 15, op_v, st_v, busy_n, nready_n);
        check("05_op", op_v, 32'b101000000101100);
        check("05_stuff", st_v, 32'b000000000000100);
        wait_idle(100);

        f0 = frames;
        pending.push_back(8'hAA);
        pending.push_back(8'h00);
        pending.push_back(8'h05);
        wait_idle(200);
        check("b2b_frames", 32'(frames - f0), 32'd3);

        f0 = frames;
        pending.push_back(8'hE3);
        wait_accept(f0);
        repeat (6) @(posedge Clk);
        #2;
        check("pre_rst_busy", 32'(Tx_Busy), 32'd1);
        check("pre_rst_op", 32'(OP), 32'd1);
        Rst = 1'b0;
        expq.delete();
        region_bits.delete();
        det_hist.delete();
        idle_now = 1'b1;
        #1;
        check("async_rst_op", 32'(OP), 32'd0);
        check("async_rst_busy", 32'(Tx_Busy), 32'd0);
        repeat (2) @(negedge Clk);
        #3 Rst = 1'b1;
        #1 check("post_rst_ready", 32'(In_Ready), 32'd1);
        f0 = frames;
        pending.push_back(8'h5A);
        wait_idle(100);
        check("post_rst_frame", 32'(frames - f0), 32'd1);

        holdoff_en = 1'b1;
        f0 = frames;
        for (int i = 0; i < 3000; i++) pending.push_back(DATA_W'($urandom));
        wait_idle(3000 * 40);
        check("rand_frames", 32'(frames - f0), 32'd3000);

        check("hits_vs_frames", 32'(hits), 32'(frames));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
